// File: rtl/uartm_ahb_pkg.sv
// Shared encodings for the UART-side AHB-lite master arbiter.
package uartm_ahb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [3:0] HSIZE_WORD    = 4'b0010;

endpackage

// File: rtl/uartm_rr_arb2.sv
// Two-way round-robin pick: a lone request wins, on a tie the requester that did not win last time wins.
module uartm_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  assign winner = (&req) ? ~last : req[1];

endmodule

// File: rtl/uartm_ahb_arb.sv
// Shares one AHB-lite master port between two requesters; one single-beat word NONSEQ per grant,
// with wait-state timeout and per-requester read data / error return.
module uartm_ahb_arb
  import uartm_ahb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int TO_W        = 9
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic        write0,
  input  logic [31:0] wdata0,
  output logic        gnt0,
  output logic        done0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic        write1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        done1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [31:0] hwdata,
  output logic [3:0]  hsize,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        timeout
);

  state_t          state;
  logic            last;
  logic            owner;
  logic [TO_W-1:0] wait_cnt;
  logic            valid;
  logic            winner;
  logic            at_limit;
  logic            abort;
  logic            finish;

  uartm_rr_arb2 u_pick (
    .req    ({req1, req0}),
    .last   (last),
    .valid  (valid),
    .winner (winner)
  );

  assign hsize    = HSIZE_WORD;
  assign at_limit = (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign abort    = ((state == ST_ADDR) || (state == ST_DATA)) && !hready && at_limit;
  assign finish   = (state == ST_DATA) && hready;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= ST_IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      wait_cnt <= '0;
      htrans   <= HTRANS_IDLE;
      haddr    <= '0;
      hwrite   <= 1'b0;
      hwdata   <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      timeout  <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      timeout <= 1'b0;
      // Completion and timeout share the return path; err is forced on abort.
      if (finish || abort) begin
        done0   <= ~owner;
        done1   <= owner;
        timeout <= abort;
        htrans  <= HTRANS_IDLE;
        state   <= ST_IDLE;
        if (owner) err1 <= abort | hresp;
        else       err0 <= abort | hresp;
        if (finish && !hwrite) begin
          if (owner) rdata1 <= hrdata;
          else       rdata0 <= hrdata;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            htrans <= HTRANS_IDLE;
            if (valid) begin
              haddr    <= winner ? addr1  : addr0;
              hwrite   <= winner ? write1 : write0;
              hwdata   <= winner ? wdata1 : wdata0;
              htrans   <= HTRANS_NONSEQ;
              gnt0     <= ~winner;
              gnt1     <= winner;
              last     <= winner;
              owner    <= winner;
              wait_cnt <= '0;
              state    <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (hready) begin
              htrans <= HTRANS_IDLE;
              state  <= ST_DATA;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          ST_DATA: wait_cnt <= wait_cnt + 1'b1;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uartm_ahb_arb.sv
// Randomized self-checking bench: the bench plays both requesters and the AHB slave, and predicts
// grant order, completion cycle, read data and error/timeout status from the transfer rules.
module tb_uartm_ahb_arb;

  localparam int T = 8;

  logic        hclk;
  logic        hreset;
  logic        req0, write0, gnt0, done0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req1, write1, gnt1, done1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic        hwrite, hready, hresp, timeout;
  logic [3:0]  hsize;

  int checks = 0;
  int errors = 0;

  int          lastW;
  logic [31:0] expRdata [2];
  logic        expErr   [2];
  logic [31:0] expHaddr, expHwdata;
  logic        expHwrite;
  logic        pend   [2];
  logic [31:0] pAddr  [2];
  logic [31:0] pWdata [2];
  logic        pWrite [2];

  uartm_ahb_arb #(.TIMEOUT_CYC(T), .TO_W(4)) dut (
    .hclk(hclk), .hreset(hreset),
    .req0(req0), .addr0(addr0), .write0(write0), .wdata0(wdata0),
    .gnt0(gnt0), .done0(done0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .addr1(addr1), .write1(write1), .wdata1(wdata1),
    .gnt1(gnt1), .done1(done1), .rdata1(rdata1), .err1(err1),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata), .hsize(hsize),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .timeout(timeout)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic hrdy, input logic hrsp, input logic [31:0] hrd);
    hreset = rst;
    req0   = pend[0];  addr0 = pAddr[0];  write0 = pWrite[0];  wdata0 = pWdata[0];
    req1   = pend[1];  addr1 = pAddr[1];  write1 = pWrite[1];  wdata1 = pWdata[1];
    hready = hrdy;
    hresp  = hrsp;
    hrdata = hrd;
  endtask

  task automatic checkCycle(input logic [1:0] gntE, input logic [1:0] doneE, input logic toE,
                            input logic [1:0] htE);
    checkOutput("gnt0", gnt0, gntE[0]);
    checkOutput("gnt1", gnt1, gntE[1]);
    checkOutput("done0", done0, doneE[0]);
    checkOutput("done1", done1, doneE[1]);
    checkOutput("timeout", timeout, toE);
    checkOutput("htrans", htrans, htE);
    checkOutput("haddr", haddr, expHaddr);
    checkOutput("hwrite", hwrite, expHwrite);
    checkOutput("hwdata", hwdata, expHwdata);
    checkOutput("hsize", hsize, 4'b0010);
    checkOutput("rdata0", rdata0, expRdata[0]);
    checkOutput("rdata1", rdata1, expRdata[1]);
    checkOutput("err0", err0, expErr[0]);
    checkOutput("err1", err1, expErr[1]);
  endtask

  task automatic checkReset();
    lastW       = 1;
    expHaddr    = '0;
    expHwdata   = '0;
    expHwrite   = 1'b0;
    expRdata[0] = '0;
    expRdata[1] = '0;
    expErr[0]   = 1'b0;
    expErr[1]   = 1'b0;
    checkCycle(2'b00, 2'b00, 1'b0, 2'b00);
  endtask

  task automatic postRequest(input int r, input logic [31:0] a, input logic wr, input logic [31:0] wd);
    pend[r]   = 1'b1;
    pAddr[r]  = a;
    pWrite[r] = wr;
    pWdata[r] = wd;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, $urandom);
    @(negedge hclk);
    checkCycle(2'b00, 2'b00, 1'b0, 2'b00);
  endtask

  // Called at the negedge of an IDLE cycle with requests posted; aw/dw are wait cycles in the
  // address and data phases, rstCyc (if nonzero) asserts reset after that cycle's checks.
  task automatic runTransfer(input int aw, input int dw, input logic er, input logic [31:0] rd,
                             input int rstCyc);
    int          w;
    int          doneCyc;
    bit          isTo;
    logic        wr;
    logic        hrdy, hrsp;
    logic [31:0] hrd;
    logic [1:0]  gE, dE;
    w       = (pend[0] && pend[1]) ? 1 - lastW : (pend[1] ? 1 : 0);
    lastW   = w;
    wr      = pWrite[w];
    isTo    = (aw + dw >= T);
    doneCyc = isTo ? ((aw >= T) ? T + 1 : T + 2) : aw + dw + 3;
    applyStimulus(1'b0, 1'b1, 1'b0, $urandom);
    expHaddr  = pAddr[w];
    expHwrite = wr;
    expHwdata = pWdata[w];
    for (int c = 1; c <= doneCyc; c++) begin
      @(negedge hclk);
      if (c == doneCyc) begin
        expErr[w] = isTo ? 1'b1 : er;
        if (!isTo && !wr) expRdata[w] = rd;
      end
      gE = (c == 1)       ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
      dE = (c == doneCyc) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
      checkCycle(gE, dE, isTo && (c == doneCyc), (c <= aw + 1 && c < doneCyc) ? 2'b10 : 2'b00);
      if (c == 1) pend[w] = 1'b0;
      hrd  = $urandom;
      hrsp = 1'b0;
      if (c <= aw) begin
        hrdy = 1'b0;
      end else if (c == aw + 1) begin
        hrdy = 1'b1;
      end else if (c <= aw + 1 + dw) begin
        hrdy = 1'b0;
        hrsp = er && (c == aw + 1 + dw);
      end else begin
        hrdy = 1'b1;
        if (c == aw + dw + 2) begin
          hrsp = er;
          hrd  = rd;
        end
      end
      if (c == rstCyc) begin
        applyStimulus(1'b1, hrdy, hrsp, hrd);
        @(negedge hclk);
        checkReset();
        applyStimulus(1'b0, 1'b1, 1'b0, $urandom);
        return;
      end
      applyStimulus(1'b0, hrdy, hrsp, hrd);
    end
  endtask

  initial begin
    int aw, dw;
    logic er;
    pend[0] = 1'b0;  pAddr[0] = '0;  pWrite[0] = 1'b0;  pWdata[0] = '0;
    pend[1] = 1'b0;  pAddr[1] = '0;  pWrite[1] = 1'b0;  pWdata[1] = '0;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    repeat (2) @(negedge hclk);
    checkReset();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);

    // Single write, zero waits: gnt at 1, done at 3.
    postRequest(0, 32'h4000_0010, 1'b1, 32'hDEAD_BEEF);
    runTransfer(0, 0, 1'b0, $urandom, 0);
    // Read with three data-phase waits.
    postRequest(1, 32'h2000_0000, 1'b0, $urandom);
    runTransfer(0, 3, 1'b0, 32'h1234_5678, 0);
    // Two-cycle error response, then a clean transfer.
    postRequest(0, $urandom, 1'b0, $urandom);
    runTransfer(0, 1, 1'b1, $urandom, 0);
    postRequest(0, $urandom, 1'b0, $urandom);
    runTransfer(0, 0, 1'b0, $urandom, 0);
    // Timeouts in the data phase and in the address phase.
    postRequest(1, $urandom, 1'b0, $urandom);
    runTransfer(0, T, 1'b0, $urandom, 0);
    postRequest(0, $urandom, 1'b1, $urandom);
    runTransfer(T, 0, 1'b0, $urandom, 0);
    // Continuous contention: grants alternate.
    repeat (4) begin
      if (!pend[0]) postRequest(0, $urandom, 1'($urandom_range(0, 1)), $urandom);
      if (!pend[1]) postRequest(1, $urandom, 1'($urandom_range(0, 1)), $urandom);
      runTransfer(0, $urandom_range(0, 2), 1'b0, $urandom, 0);
    end
    // Reset in the middle of the data phase, then a tie goes to requester 0.
    if (!pend[0] && !pend[1]) postRequest(0, $urandom, 1'b0, $urandom);
    runTransfer(0, 5, 1'b0, $urandom, 3);
    if (!pend[0]) postRequest(0, $urandom, 1'b0, $urandom);
    if (!pend[1]) postRequest(1, $urandom, 1'b0, $urandom);
    runTransfer(0, 0, 1'b0, $urandom, 0);

    repeat (40) begin
      if (!pend[0] && !pend[1] && $urandom_range(0, 4) == 0) idleCycle();
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1)
          postRequest(r, $urandom, 1'($urandom_range(0, 1)), $urandom);
      if (!pend[0] && !pend[1])
        postRequest($urandom_range(0, 1), $urandom, 1'($urandom_range(0, 1)), $urandom);
      aw = $urandom_range(0, 2);
      er = ($urandom_range(0, 3) == 0);
      dw = ($urandom_range(0, 7) == 0) ? $urandom_range(T - aw, T + 1) : $urandom_range(er ? 1 : 0, 3);
      runTransfer(aw, dw, er, $urandom, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
